fdiv_issue_ctrl: RTL

Sequencing controller and two-requester arbiter in front of the pipelined single-precision divider.
It accepts divide requests over valid/ready from two clients and grants them round-robin. It drives the divider operand bus and holds it stable for the whole pipeline latency, because the divider's special-case path samples the live operands at its final stage. It captures the divider result after a fixed latency and returns it on a tagged response channel with backpressure.
Exactly one operation is in flight at a time.

---
 rtl/fdiv_issue_ctrl_pkg.sv | 27 ++
 rtl/fdiv_rr_arb2.sv | 28 ++
 rtl/fdiv_issue_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/fdiv_issue_ctrl_pkg.sv
// Shared definitions for the divider front end: the controller state encoding,
// canonical special-value results, and rounding-mode codes.
package fdiv_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } divState_e;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [1:0] {
    RM_NEAREST_EVEN = 2'd0,
    RM_TO_ZERO      = 2'd1,
    RM_TO_POS_INF   = 2'd2,
    RM_TO_NEG_INF   = 2'd3
  } roundMode_e;

  // When both requesters are valid, the one that did not win last time wins now.
  function automatic logic rrPick(input logic [1:0] valid, input logic lastGrant);
    if (valid == 2'b11) return ~lastGrant;
    return valid[1];
  endfunction

endpackage

// File: rtl/fdiv_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the history bit
// only advances when the owner of this arbiter strobes update on a handshake.
module fdiv_rr_arb2
  import fdiv_issue_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] reqValid,
  input  logic       update,
  output logic       grant,
  output logic       grantValid
);

  logic lastGrant;

  assign grant      = rrPick(reqValid, lastGrant);
  assign grantValid = |reqValid;

  // Starting from 1 makes requester 0 the winner of the first contended round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant <= 1'b1;
    end else if (update) begin
      lastGrant <= grant;
    end
  end

endmodule

// File: rtl/fdiv_issue_ctrl.sv
// Issue controller for the pipelined divider: arbitrates two requesters, holds
// the operand bus for the full latency, and returns the result on a tagged channel.
module fdiv_issue_ctrl
  import fdiv_issue_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 6,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_rmode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_rmode,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_error,
  output logic        resp_overflow,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic [1:0]  div_round_mode,
  input  logic [31:0] div_result,
  input  logic        div_error,
  input  logic        div_overflow,
  output logic        busy
);

  divState_e        state;
  divState_e        stateNext;
  logic [CNT_W-1:0] cnt;
  logic             grant;
  logic             grantValid;
  logic             accept;
  logic             capture;
  logic             respDone;

  fdiv_rr_arb2 uArb (
    .clk       (clk),
    .rst       (rst),
    .reqValid  ({req1_valid, req0_valid}),
    .update    (accept),
    .grant     (grant),
    .grantValid(grantValid)
  );

  // Ready is offered only to the current winner, so valid&&ready reduces to grantValid.
  assign accept     = (state == IDLE) && grantValid;
  assign capture    = (state == WAIT) && (cnt == CNT_W'(1));
  assign respDone   = (state == RESP) && resp_ready;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept)   stateNext = WAIT;
      WAIT:    if (capture)  stateNext = RESP;
      RESP:    if (respDone) stateNext = IDLE;
      default:               stateNext = IDLE;
    endcase
  end

  // Operands are written only on acceptance, so they stay put through WAIT and
  // keep the last values while idle; the divider's final stage reads them live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_a          <= '0;
      div_b          <= '0;
      div_round_mode <= '0;
      cnt            <= '0;
      resp_valid     <= 1'b0;
      resp_id        <= 1'b0;
      resp_result    <= '0;
      resp_error     <= 1'b0;
      resp_overflow  <= 1'b0;
    end else begin
      if (accept) begin
        div_a          <= grant ? req1_a     : req0_a;
        div_b          <= grant ? req1_b     : req0_b;
        div_round_mode <= grant ? req1_rmode : req0_rmode;
        resp_id        <= grant;
        cnt            <= CNT_W'(DIV_LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        resp_result   <= div_result;
        resp_error    <= div_error;
        resp_overflow <= div_overflow;
        resp_valid    <= 1'b1;
      end else if (respDone) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule
